// File: rtl/spi_transfer_core.sv
// spi_transfer_core: SPI master shift engine with baud divider, CPOL/CPHA/LSBFE and abort handling
module spi_transfer_core (
  input  logic       PCLK,
  input  logic       PRESET_n,
  input  logic       send_data_i,
  input  logic [7:0] mosi_data_i,
  input  logic       mstr_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       lsbfe_i,
  input  logic       spiswai_i,
  input  logic [1:0] spi_mode_i,
  input  logic [2:0] sppr_i,
  input  logic [2:0] spr_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       ss_o,
  output logic       tip_o,
  output logic       receive_data_o,
  output logic [7:0] miso_data_o
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t      r_state;
  logic [10:0] r_half;
  logic [10:0] r_cnt;
  logic [4:0]  r_edges;
  logic [7:0]  r_tx;
  logic [7:0]  r_rx;
  logic [7:0]  r_miso_data;
  logic        r_lsbfe;
  logic        r_cpha;
  logic        r_ph;
  logic        r_mosi;
  logic        r_ss;
  logic        r_tip;
  logic        r_rxv;
  logic [10:0] w_half;
  logic [2:0]  w_n;
  logic [2:0]  w_idx;
  logic        w_start;
  logic        w_abort;
  logic        w_tick;
  logic        w_lead;
  logic        w_drive;
  logic        w_sample;
  logic        w_done;
  // Half period in PCLK cycles: (sppr+1) * 2^spr, i.e. half of the full divisor
  assign w_half   = 11'(sppr_i + 4'd1) << spr_i;
  assign w_start  = r_state == IDLE && send_data_i && mstr_i &&
                    (spi_mode_i == 2'b00 || (spi_mode_i == 2'b01 && !spiswai_i));
  assign w_abort  = r_state == XFER &&
                    (spi_mode_i == 2'b10 || (spi_mode_i == 2'b01 && spiswai_i) || !mstr_i);
  assign w_tick   = r_cnt == r_half - 11'd1;
  assign w_done   = w_tick && r_edges == 5'd16;
  // r_edges counts toggles already made; the upcoming toggle is leading when that count is even
  assign w_lead   = ~r_edges[0];
  assign w_n      = r_cpha ? r_edges[3:1] : r_edges[3:1] + {2'b00, r_edges[0]};
  assign w_idx    = r_lsbfe ? w_n : 3'd7 - w_n;
  assign w_drive  = r_cpha ? w_lead : (!w_lead && r_edges != 5'd15);
  assign w_sample = r_cpha ^ w_lead;
  assign sclk_o         = cpol_i ^ (r_tip & r_ph);
  assign mosi_o         = r_mosi;
  assign ss_o           = r_ss;
  assign tip_o          = r_tip;
  assign receive_data_o = r_rxv;
  assign miso_data_o    = r_miso_data;
  // Transfer sequencing: start capture, half-period timing, shifting, completion and abort
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      r_state     <= IDLE;
      r_half      <= 11'd1;
      r_cnt       <= '0;
      r_edges     <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_miso_data <= '0;
      r_lsbfe     <= 1'b0;
      r_cpha      <= 1'b0;
      r_ph        <= 1'b0;
      r_mosi      <= 1'b0;
      r_ss        <= 1'b1;
      r_tip       <= 1'b0;
      r_rxv       <= 1'b0;
    end else begin
      r_rxv <= 1'b0;
      if (r_state == IDLE) begin
        if (w_start) begin
          r_state <= XFER;
          r_ss    <= 1'b0;
          r_tip   <= 1'b1;
          r_half  <= w_half;
          r_tx    <= mosi_data_i;
          r_lsbfe <= lsbfe_i;
          r_cpha  <= cpha_i;
          r_cnt   <= '0;
          r_edges <= '0;
          r_ph    <= 1'b0;
          if (!cpha_i) r_mosi <= mosi_data_i[lsbfe_i ? 3'd0 : 3'd7];
        end
      end else if (w_abort || w_done) begin
        r_state <= IDLE;
        r_ss    <= 1'b1;
        r_tip   <= 1'b0;
        r_cnt   <= '0;
        r_edges <= '0;
        r_ph    <= 1'b0;
        r_rxv   <= !w_abort;
        if (!w_abort) r_miso_data <= r_rx;
      end else if (w_tick) begin
        r_cnt   <= '0;
        r_edges <= r_edges + 5'd1;
        if (r_edges != 5'd16) r_ph <= ~r_ph;
        if (r_edges != 5'd16 && w_drive) r_mosi <= r_tx[w_idx];
        if (r_edges != 5'd16 && w_sample) r_rx <= r_lsbfe ? {miso_i, r_rx[7:1]} : {r_rx[6:0], miso_i};
      end else begin
        r_cnt <= r_cnt + 11'd1;
      end
    end
  end
endmodule

// File: tb/tb_spi_transfer_core.sv
// tb_spi_transfer_core: randomized scoreboard bench with an SPI slave model for spi_transfer_core
module tb_spi_transfer_core;
  logic       PCLK = 1'b0;
  logic       PRESET_n = 1'b0;
  logic       send_data_i = 1'b0;
  logic [7:0] mosi_data_i = 8'h00;
  logic       mstr_i = 1'b1;
  logic       cpol_i = 1'b0;
  logic       cpha_i = 1'b0;
  logic       lsbfe_i = 1'b0;
  logic       spiswai_i = 1'b0;
  logic [1:0] spi_mode_i = 2'b00;
  logic [2:0] sppr_i = 3'd0;
  logic [2:0] spr_i = 3'd0;
  logic       miso_i;
  logic       sclk_o, mosi_o, ss_o, tip_o, receive_data_o;
  logic [7:0] miso_data_o;

  spi_transfer_core dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .send_data_i(send_data_i), .mosi_data_i(mosi_data_i),
    .mstr_i(mstr_i), .cpol_i(cpol_i), .cpha_i(cpha_i), .lsbfe_i(lsbfe_i), .spiswai_i(spiswai_i),
    .spi_mode_i(spi_mode_i), .sppr_i(sppr_i), .spr_i(spr_i), .miso_i(miso_i),
    .sclk_o(sclk_o), .mosi_o(mosi_o), .ss_o(ss_o), .tip_o(tip_o),
    .receive_data_o(receive_data_o), .miso_data_o(miso_data_o)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] sb;
    int         h;
    bit         cpol;
    bit         cpha;
    bit         lsb;
    int         abort_at;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int idx(input bit lsb, input int n);
    return lsb ? n : 7 - n;
  endfunction

  // Monitor: follows each ss_o-low window, plays the slave byte on miso_i, records mosi_o at every sampling edge
  exp_t       cur;
  bit         in_x = 0;
  bit         tbad;
  int         cyc, tog, ns;
  logic       psclk, pmosi;
  logic [7:0] rtx;
  logic [7:0] last_rx = 8'h00;

  always @(negedge PCLK) begin
    if (!PRESET_n) begin
      if (in_x) void'(q.pop_front());
      in_x = 0;
      last_rx = 8'h00;
      miso_i = 1'b0;
    end else if (!in_x) begin
      chk("rx_idle", int'(receive_data_o), 0);
      if (!ss_o) begin
        if (q.size() == 0) begin
          chk("unexpected_start", int'(ss_o), 1);
        end else begin
          cur = q[0];
          in_x = 1;
          cyc = 0;
          tog = 0;
          ns = 0;
          tbad = 0;
          rtx = 8'h00;
          miso_i = cur.sb[idx(cur.lsb, 0)];
        end
      end
    end else begin
      cyc++;
      if (sclk_o !== psclk) begin
        tog++;
        if (cyc != tog * cur.h || tog > 16) tbad = 1;
        if ((sclk_o != cur.cpol) ^ cur.cpha) begin
          if (ns < 8) rtx[idx(cur.lsb, ns)] = pmosi;
          ns++;
          if (ns < 8) miso_i = cur.sb[idx(cur.lsb, ns)];
        end
      end
      if (!ss_o && !tip_o) tbad = 1;
      if (ss_o) begin
        in_x = 0;
        void'(q.pop_front());
        chk("tip_end", int'(tip_o), 0);
        chk("sclk_idle", int'(sclk_o), int'(cur.cpol));
        if (cur.abort_at != 0) begin
          chk("abort_cycle", cyc, cur.abort_at);
          chk("abort_no_rx", int'(receive_data_o), 0);
          chk("abort_keep", int'(miso_data_o), int'(last_rx));
        end else begin
          chk("ss_len", cyc, 17 * cur.h);
          chk("toggles", tog, 16);
          chk("timing", int'(tbad), 0);
          chk("mosi_byte", int'(rtx), int'(cur.tx));
          chk("rx_pulse", int'(receive_data_o), 1);
          chk("miso_data", int'(miso_data_o), int'(cur.sb));
          last_rx = cur.sb;
        end
      end
    end
    psclk = sclk_o;
    pmosi = mosi_o;
  end

  task automatic run(input logic [7:0] tx, input logic [7:0] sb, input int sppr, input int spr,
                     input bit cpol, input bit cpha, input bit lsb, input int abort_after, input bit noise);
    exp_t e;
    bit done;
    cpol_i = cpol;
    cpha_i = cpha;
    lsbfe_i = lsb;
    sppr_i = 3'(sppr);
    spr_i = 3'(spr);
    mosi_data_i = tx;
    e.tx = tx;
    e.sb = sb;
    e.h = (sppr + 1) * (2 ** spr);
    e.cpol = cpol;
    e.cpha = cpha;
    e.lsb = lsb;
    e.abort_at = abort_after != 0 ? abort_after * e.h + 1 : 0;
    q.push_back(e);
    @(posedge PCLK); #1;
    send_data_i = 1'b1;
    @(posedge PCLK); #1;
    send_data_i = 1'b0;
    if (abort_after != 0) begin
      repeat (abort_after * e.h) @(posedge PCLK);
      #1 spi_mode_i = 2'b10;
      @(posedge PCLK); #1;
      spi_mode_i = 2'b00;
    end else begin
      done = 0;
      for (int c = 0; c < 20000 && !done; c++) begin
        @(posedge PCLK); #1;
        if (ss_o) done = 1;
        else if (noise) begin
          send_data_i = 1'($urandom);
          sppr_i = 3'($urandom);
          spr_i = 3'($urandom);
          mosi_data_i = 8'($urandom);
        end
      end
      send_data_i = 1'b0;
      if (!done) begin
        errs++;
        $display("FAIL timeout: ss_o still low after 20000 cycles");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $fatal(1, "transfer never completed");
      end
    end
    repeat (3) @(posedge PCLK);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge PCLK);
    chk("rst_ss", int'(ss_o), 1);
    chk("rst_tip", int'(tip_o), 0);
    chk("rst_mosi", int'(mosi_o), 0);
    chk("rst_miso_data", int'(miso_data_o), 0);
    chk("rst_sclk", int'(sclk_o), 0);
    #1 PRESET_n = 1'b1;
    run(8'hA5, 8'hA5, 0, 0, 0, 0, 0, 0, 0);
    run(8'h3C, 8'h5A, 1, 1, 0, 0, 0, 0, 1);
    run(8'h01, 8'hFF, 0, 0, 1, 1, 1, 0, 0);
    run(8'hC3, 8'h96, 0, 1, 0, 1, 0, 5, 0);
    run(8'h7E, 8'h81, 1, 0, 1, 0, 1, 3, 0);
    for (int i = 0; i < 16; i++) begin
      spi_mode_i = 2'($urandom_range(0, 1));
      run(8'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom), 1'($urandom), 1'($urandom), 0, 1);
    end
    spi_mode_i = 2'b00;
    mstr_i = 1'b0;
    send_data_i = 1'b1;
    repeat (4) @(posedge PCLK);
    #1 chk("no_start_mstr0", int'(ss_o), 1);
    mstr_i = 1'b1;
    spi_mode_i = 2'b01;
    spiswai_i = 1'b1;
    repeat (4) @(posedge PCLK);
    #1 chk("no_start_wait", int'(tip_o), 0);
    send_data_i = 1'b0;
    spi_mode_i = 2'b00;
    spiswai_i = 1'b0;
    cpol_i = 1'b1;
    q.push_back('{tx: 8'hF0, sb: 8'h0F, h: 2, cpol: 1'b1, cpha: 1'b0, lsb: 1'b0, abort_at: 1});
    mosi_data_i = 8'hF0;
    sppr_i = 3'd1;
    spr_i = 3'd0;
    send_data_i = 1'b1;
    @(posedge PCLK); #1;
    send_data_i = 1'b0;
    repeat (9) @(posedge PCLK);
    #2 PRESET_n = 1'b0;
    #1;
    chk("mid_rst_ss", int'(ss_o), 1);
    chk("mid_rst_tip", int'(tip_o), 0);
    chk("mid_rst_rx", int'(receive_data_o), 0);
    chk("mid_rst_mosi", int'(mosi_o), 0);
    chk("mid_rst_miso_data", int'(miso_data_o), 0);
    chk("mid_rst_sclk", int'(sclk_o), 1);
    repeat (2) @(posedge PCLK);
    #1 PRESET_n = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 chk("post_rst_sclk", int'(sclk_o), 1);
    run(8'h96, 8'h3C, 2, 2, 1, 1, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
